rot_sched: RTL
==============

ROT_SCHED -- requirements
Module: rot_sched

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared rotate register.
REQ-002 Parameter AMT_W, default 3, width of rotate-amount field (max amount 2^AMT_W-1).
REQ-003 clk  input  1  single clock, all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-007 req_data0, req_data1  input  WIDTH  operand from requester 0 / 1.
REQ-008 req_amt0, req_amt1  input  AMT_W  left-rotate amount from requester 0 / 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  requester index owning current result.
REQ-012 rsp_data  output  WIDTH  rotated result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE, ROTATE, DONE.
REQ-015 IDLE: when any req_valid bit is high, the block SHALL assert req_ready for exactly one granted requester in the same cycle (combinational from state and req_valid).
REQ-016 Arbitration SHALL be round-robin: on simultaneous requests, grant goes to the requester not served last; a single request is granted regardless of pointer.
REQ-017 The last-served pointer SHALL update only on a completed handshake (req_valid & req_ready).
REQ-018 On handshake, the block SHALL load req_data of the granted requester into the data register, load req_amt into a down-counter, capture rsp_id, and go to ROTATE if amt != 0, else DONE.
REQ-019 ROTATE: each cycle the data register SHALL rotate left by one bit (MSB into LSB) and the counter SHALL decrement; on the cycle the counter goes 1 -> 0 the FSM SHALL go to DONE.
REQ-020 Latency: handshake in cycle T gives rsp_valid high from cycle T+1+amt (amt=0 -> T+1).
REQ-021 DONE: rsp_valid SHALL be high and rsp_data/rsp_id SHALL be stable until rsp_valid & rsp_ready; then FSM returns to IDLE next cycle.
REQ-022 req_ready SHALL be low in ROTATE and DONE; no new request is accepted in the cycle the response handshakes (earliest next accept is the following IDLE cycle).
REQ-023 rsp_data SHALL equal the data register at all times; it is only meaningful while rsp_valid is high.
REQ-024 Counter arithmetic SHALL be unsigned AMT_W bits with no wrap below zero.
REQ-025 Requester inputs SHALL be ignored outside the handshake cycle; deassertion of req_valid before grant is legal and cancels nothing in progress.

Reset
REQ-026 While reset is high at a clock edge: state -> IDLE, data register -> 0, counter -> 0, rsp_id -> 0, round-robin pointer -> favour requester 0.
REQ-027 Reset mid-ROTATE or mid-DONE SHALL abort the operation with no response; rsp_valid, busy low the cycle after reset.
REQ-028 During reset cycles req_ready SHALL be 0.

Structure
REQ-029 FSM state encoding and WIDTH/AMT_W defaults SHALL live in a shared package rot_pkg.
REQ-030 The rotate datapath (load, rotate-left-by-one, hold, sync clear) SHALL be a sub-module rot_reg; rot_sched contains arbiter, counter and FSM.

Verification
REQ-031 Req0 data 8'b10110011 amt 1 -> rsp_valid at T+2, rsp_data 8'b01100111, rsp_id 0.
REQ-032 Req1 data 8'b10110011 amt 3 -> rsp at T+4, rsp_data 8'b10011101, rsp_id 1; busy high T+1..T+4.
REQ-033 Req0 amt 0 data 8'hA5 -> rsp at T+1, rsp_data 8'hA5.
REQ-034 Both requesters held valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; neither starved.
REQ-035 rsp_ready held low 5 cycles in DONE -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 0.
REQ-036 Reset asserted during ROTATE with amt 7 -> next cycle IDLE, rsp_data 0, no rsp_valid; following request from both grants requester 0 first.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared definitions for the round-robin rotate scheduler: default widths
// and the FSM state encoding used by rot_sched.
package rot_pkg;

  localparam int ROT_WIDTH = 8;
  localparam int ROT_AMT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rot_reg.sv
// Rotate datapath register: parallel load, rotate-left-by-one, hold, and
// synchronous clear. Load takes priority over shift.
module rot_reg #(
  parameter int WIDTH = rot_pkg::ROT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] rot_bits;

  // Bit gi takes bit gi-1; bit 0 takes the old MSB.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
      localparam int SRC = (gi == 0) ? WIDTH - 1 : gi - 1;
      assign rot_bits[gi] = data_reg[SRC];
    end
  endgenerate

  always_comb begin
    data_next = data_reg;
    if (load) begin
      data_next = load_data;
    end else if (shift) begin
      data_next = rot_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

  assign q = data_reg;

endmodule

// File: rtl/rot_sched.sv
// Two-requester round-robin scheduler feeding a shared left-rotate unit.
// Holds arbiter, amount down-counter and IDLE/ROTATE/DONE FSM.
module rot_sched
  import rot_pkg::*;
#(
  parameter int WIDTH = ROT_WIDTH,
  parameter int AMT_W = ROT_AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [AMT_W-1:0] req_amt0,
  input  logic [AMT_W-1:0] req_amt1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [AMT_W-1:0] cnt_reg, cnt_next;
  logic             id_reg, id_next;
  logic             last_reg, last_next;

  logic [1:0]       grant;
  logic             hs;
  logic             hs_id;
  logic [WIDTH-1:0] sel_data;
  logic [AMT_W-1:0] sel_amt;
  logic             load;
  logic             shift;

  // Grants are only offered in IDLE and never while reset is asserted.
  // On contention the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (state_reg == ST_IDLE && !reset) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_reg ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign hs        = |(req_valid & grant);
  assign hs_id     = grant[1];
  assign sel_data  = hs_id ? req_data1 : req_data0;
  assign sel_amt   = hs_id ? req_amt1 : req_amt0;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    id_next    = id_reg;
    last_next  = last_reg;
    load       = 1'b0;
    shift      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (hs) begin
          load       = 1'b1;
          cnt_next   = sel_amt;
          id_next    = hs_id;
          last_next  = hs_id;
          state_next = (sel_amt != '0) ? ST_ROTATE : ST_DONE;
        end
      end
      ST_ROTATE: begin
        shift = 1'b1;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end
        // The step that takes the counter from 1 to 0 is the last rotation.
        if (cnt_reg <= 1) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // last_reg resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      id_reg    <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      id_reg    <= id_next;
      last_reg  <= last_next;
    end
  end

  rot_reg #(
    .WIDTH(WIDTH)
  ) u_rot_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(sel_data),
    .shift    (shift),
    .q        (rsp_data)
  );

  assign rsp_valid = (state_reg == ST_DONE);
  assign rsp_id    = id_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule
